shared_queue_arbiter: RTL and testbench

- Round-robin arbiter that lets NUM_REQ requesters share one DEPTH-entry in-order queue. One entry is accepted per cycle.
- Grants are gated by queue occupancy, so no requester can overflow the queue. A single consumer drains the queue with a valid/ack handshake.
- Sits between issue-side producers (e.g. several units needing one shared writeback or memory-request path) and that single consumer.

---
 rtl/shared_queue_arbiter_pkg.sv | 17 +
 rtl/rr_priority_select.sv | 40 ++++
 rtl/shared_queue_arbiter.sv | 94 +++++++++
 tb/tb_shared_queue_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/shared_queue_arbiter_pkg.sv
// Shared types and helpers for the shared-queue arbiter and the arbiters built around it.
package shared_queue_arbiter_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    // Index width that never collapses to zero bits for single-entry cases.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]          data;
        logic [clog2_min1(DEF_NUM_REQ)-1:0] src;
    } queue_entry_t;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first set request at or after the priority pointer.
module rr_priority_select
    import shared_queue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_prio,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    int unsigned w_cand;
    logic        w_found;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_cand  = 0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = {{(32 - IDX_W){1'b0}}, i_prio} + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                o_idx   = w_cand[IDX_W-1:0];
            end
        end
        o_valid = w_found & i_en;
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_queue_arbiter.sv
// Round-robin arbiter feeding one in-order queue; grants are withheld when no slot is free.
module shared_queue_arbiter
    import shared_queue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned SRC_W     = clog2_min1(NUM_REQ)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 i_req,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                 o_gnt,
    output logic                               o_out_valid,
    output logic [DATA_WIDTH-1:0]              o_out_data,
    output logic [SRC_W-1:0]                   o_out_src,
    input  logic                               i_out_ack,
    output logic                               o_full,
    output logic                               o_almost_full,
    output logic                               o_empty
);

    localparam int unsigned PTR_W = clog2_min1(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [SRC_W-1:0]      src;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [SRC_W-1:0] r_prio;
    logic [DEPTH:0]   r_occ;

    logic             w_pop;
    logic             w_push;
    logic             w_space;
    logic [SRC_W-1:0] w_gnt_idx;

    assign w_pop   = i_out_ack & ~r_occ[0];
    assign w_space = ~r_occ[DEPTH] | w_pop;

    // Enable low during reset keeps gnt at zero and suppresses the accept.
    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SRC_W)
    ) u_select (
        .i_req   (i_req),
        .i_prio  (r_prio),
        .i_en    (w_space & ~rst),
        .o_gnt   (o_gnt),
        .o_idx   (w_gnt_idx),
        .o_valid (w_push)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ    <= {{DEPTH{1'b0}}, 1'b1};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_prio   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_prio   <= (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_occ <= {r_occ[DEPTH-1:0], 1'b0};
            end else if (w_pop && !w_push) begin
                r_occ <= {1'b0, r_occ[DEPTH:1]};
            end
        end
    end

    // Storage is deliberately not reset; the occupancy chain says what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{data: i_req_data[w_gnt_idx], src: w_gnt_idx};
        end
    end

    assign o_out_data    = r_mem[r_rd_ptr].data;
    assign o_out_src     = r_mem[r_rd_ptr].src;
    assign o_out_valid   = ~r_occ[0];
    assign o_empty       = r_occ[0];
    assign o_almost_full = r_occ[DEPTH-1];
    assign o_full        = r_occ[DEPTH];

endmodule

// File: tb/tb_shared_queue_arbiter.sv
// Directed plus randomized bench for shared_queue_arbiter against a queue-based reference model.
module tb_shared_queue_arbiter;

    localparam int NR = 4;
    localparam int DP = 4;
    localparam int DW = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          req;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          gnt;
    logic                   out_valid;
    logic [DW-1:0]          out_data;
    logic [1:0]             out_src;
    logic                   out_ack;
    logic                   full;
    logic                   almost_full;
    logic                   empty;

    typedef struct {
        logic [DW-1:0] d;
        int            s;
    } ent_t;

    ent_t          mq[$];
    int            prio;
    logic [DW-1:0] lane_data [NR];
    logic [NR-1:0] last_gnt;
    logic [DW-1:0] fill_data [DP];
    int            n_vec = 0;
    int            n_err = 0;

    shared_queue_arbiter #(
        .NUM_REQ    (NR),
        .DEPTH      (DP),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (req),
        .i_req_data    (req_data),
        .o_gnt         (gnt),
        .o_out_valid   (out_valid),
        .o_out_data    (out_data),
        .o_out_src     (out_src),
        .i_out_ack     (out_ack),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_empty       (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic randomize_lanes();
        for (int i = 0; i < NR; i++) lane_data[i] = $urandom;
    endtask

    task automatic check_state();
        int sz;
        sz = mq.size();
        check("empty", 64'(empty), 64'(sz == 0));
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        check("full", 64'(full), 64'(sz == DP));
        check("almost_full", 64'(almost_full), 64'(sz == DP - 1));
        if (sz != 0) begin
            check("out_data", 64'(out_data), 64'(mq[0].d));
            check("out_src", 64'(out_src), 64'(mq[0].s));
        end
    endtask

    // One clock cycle: apply inputs, compare against the model, clock, update the model.
    task automatic cycle(input logic [NR-1:0] r_req, input logic ack, input logic r_rst);
        logic [NR-1:0] exp_g;
        int            g;
        bit            space;
        ent_t          e;
        rst     = r_rst;
        req     = r_req;
        out_ack = ack;
        for (int i = 0; i < NR; i++) req_data[i] = lane_data[i];
        #2;
        exp_g = '0;
        g     = -1;
        space = (mq.size() < DP) || (ack && mq.size() != 0);
        if (!r_rst && space) begin
            for (int k = 0; k < NR; k++) begin
                if (g < 0 && r_req[(prio + k) % NR]) g = (prio + k) % NR;
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;
        last_gnt = gnt;
        check("gnt", 64'(gnt), 64'(exp_g));
        check_state();
        @(posedge clk);
        if (r_rst) begin
            mq.delete();
            prio = 0;
        end else begin
            if (ack && mq.size() != 0) void'(mq.pop_front());
            if (g >= 0) begin
                e.d = lane_data[g];
                e.s = g;
                mq.push_back(e);
                prio = (g + 1) % NR;
            end
        end
        #1;
        randomize_lanes();
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        out_ack = 1'b0;
        randomize_lanes();
        for (int i = 0; i < NR; i++) req_data[i] = lane_data[i];
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        prio = 0;
        cycle(4'b1111, 1'b0, 1'b1);
        check("rst_gnt", 64'(last_gnt), 64'h0);

        // Single push then pop.
        lane_data[1] = 32'hA5;
        cycle(4'b0010, 1'b0, 1'b0);
        check("tp1_gnt", 64'(last_gnt), 64'b0010);
        check("tp1_valid", 64'(out_valid), 64'h1);
        check("tp1_data", 64'(out_data), 64'hA5);
        check("tp1_src", 64'(out_src), 64'h1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("tp1_empty", 64'(empty), 64'h1);

        // Round-robin with all requesting and the consumer always ready.
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            check("rr_gnt", 64'(last_gnt), 64'(1 << (i % NR)));
        end

        // Fill without ack, then push into full with a simultaneous pop.
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i < DP) fill_data[i] = lane_data[0];
            cycle(4'b0001, 1'b0, 1'b0);
            check("fill_gnt", 64'(last_gnt), (i < 4) ? 64'b0001 : 64'h0);
            if (i == 2) check("fill_af", 64'(almost_full), 64'h1);
            if (i == 3) check("fill_full", 64'(full), 64'h1);
        end
        cycle(4'b0100, 1'b1, 1'b0);
        check("fp_gnt", 64'(last_gnt), 64'b0100);
        check("fp_full", 64'(full), 64'h1);
        check("fp_head", 64'(out_data), 64'(fill_data[1]));

        // Ack on an empty queue is ignored.
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b1, 1'b0);
        check("uf_empty", 64'(empty), 64'h1);
        check("uf_valid", 64'(out_valid), 64'h0);
        cycle(4'b0001, 1'b1, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0);

        // Reset with entries queued and a non-zero priority pointer.
        for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        check("rq_gnt", 64'(last_gnt), 64'h0);
        check("rq_empty", 64'(empty), 64'h1);
        check("rq_valid", 64'(out_valid), 64'h0);
        cycle(4'b0110, 1'b0, 1'b0);
        check("rq_prio", 64'(last_gnt), 64'b0010);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b0);
        check("rq_first", 64'(last_gnt), 64'b1000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom % 3) == 0, ($urandom % 64) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
